// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch sequencer feeding the instruction register.
// Holds the PC, runs a single-word rd/ack read against instruction memory,
// then pulses rec = 2'b10 for one cycle so the IR latches ir_data.
// Optional feature macro: FETCH_TIMEOUT_EN (REQ wait counter, abort and sticky fault).
module fetch_unit #(
   parameter int ADDR_W  = 16,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_in,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [15:0]       mem_rdata,
   output logic [15:0]       ir_data,
   output logic [1:0]        rec,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              fault
);

   typedef enum logic [1:0] {IDLE, REQ, LOAD} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_rd_q, mem_rd_d;
   logic [15:0]       ir_data_q, ir_data_d;
   logic [1:0]        rec_q, rec_d;
   logic              busy_q, busy_d;
   logic              pend_vld_q, pend_vld_d;
   logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
`ifdef FETCH_TIMEOUT_EN
   // The abort fires on the REQ edge that would make the wait count reach TIMEOUT
   localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);
   logic [7:0]        wait_q, wait_d;
   logic              fault_q, fault_d;
`endif

   // Next-state and output computation; every register holds unless a state acts on it
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      mem_addr_d = mem_addr_q;
      mem_rd_d   = mem_rd_q;
      ir_data_d  = ir_data_q;
      rec_d      = 2'b00;
      pend_vld_d = pend_vld_q;
      pend_pc_d  = pend_pc_q;
`ifdef FETCH_TIMEOUT_EN
      wait_d     = wait_q;
      fault_d    = fault_q;
`endif
      case (state_q)
         IDLE: begin
            if (pc_load) pc_d = pc_in;
            if (start) begin
               mem_addr_d = pc_load ? pc_in : pc_q;
               mem_rd_d   = 1'b1;
               state_d    = REQ;
`ifdef FETCH_TIMEOUT_EN
               wait_d     = 8'd0;
               fault_d    = 1'b0;
`endif
            end
         end
         REQ: begin
            if (pc_load) begin
               pend_vld_d = 1'b1;
               pend_pc_d  = pc_in;
            end
            if (mem_ack) begin
               ir_data_d = mem_rdata;
               rec_d     = 2'b10;
               mem_rd_d  = 1'b0;
               pc_d      = pc_q + ADDR_W'(1);
               state_d   = LOAD;
            end
`ifdef FETCH_TIMEOUT_EN
            else if (wait_q == WaitLast) begin
               mem_rd_d   = 1'b0;
               fault_d    = 1'b1;
               state_d    = IDLE;
               if (pc_load)         pc_d = pc_in;
               else if (pend_vld_q) pc_d = pend_pc_q;
               pend_vld_d = 1'b0;
            end else begin
               wait_d = wait_q + 8'd1;
            end
`endif
         end
         LOAD: begin
            if (pc_load)         pc_d = pc_in;
            else if (pend_vld_q) pc_d = pend_pc_q;
            pend_vld_d = 1'b0;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers, cleared asynchronously by the active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         pc_q       <= '0;
         mem_addr_q <= '0;
         mem_rd_q   <= 1'b0;
         ir_data_q  <= 16'h0000;
         rec_q      <= 2'b00;
         busy_q     <= 1'b0;
         pend_vld_q <= 1'b0;
         pend_pc_q  <= '0;
`ifdef FETCH_TIMEOUT_EN
         wait_q     <= 8'd0;
         fault_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         mem_addr_q <= mem_addr_d;
         mem_rd_q   <= mem_rd_d;
         ir_data_q  <= ir_data_d;
         rec_q      <= rec_d;
         busy_q     <= busy_d;
         pend_vld_q <= pend_vld_d;
         pend_pc_q  <= pend_pc_d;
`ifdef FETCH_TIMEOUT_EN
         wait_q     <= wait_d;
         fault_q    <= fault_d;
`endif
      end
   end

   assign pc       = pc_q;
   assign mem_addr = mem_addr_q;
   assign mem_rd   = mem_rd_q;
   assign ir_data  = ir_data_q;
   assign rec      = rec_q;
   assign busy     = busy_q;
`ifdef FETCH_TIMEOUT_EN
   assign fault    = fault_q;
`else
   assign fault    = 1'b0;
`endif

endmodule
